sme_host_tx: RTL

- Host-side driver for the string-matching engine (SME) character interface.
- Buffers one string (up to 32 chars) and one pattern (up to 8 chars) loaded by a controller over a byte-write port.
- Serializes the buffers onto chardata/isstring/ispattern in the SME's expected order, then waits for the SME's valid/match/match_index response.
- Returns the result to the controller, with a timeout guard.

---
 rtl/sme_host_tx_if.sv | 28 ++
 rtl/sme_host_tx.sv | 97 +++++++++
 2 files changed

// File: rtl/sme_host_tx_if.sv
// sme_host_tx_if: controller write/start port, SME character bus and result handshake
interface sme_host_tx_if;
   logic       wr_en;
   logic       wr_sel;
   logic       wr_clr;
   logic [7:0] wr_data;
   logic       start_str;
   logic       start_pat;
   logic       busy;
   logic [7:0] chardata;
   logic       isstring;
   logic       ispattern;
   logic       valid;
   logic       match;
   logic [4:0] match_index;
   logic       res_valid;
   logic       res_match;
   logic [4:0] res_index;
   logic       res_timeout;
   modport master (
      output wr_en, wr_sel, wr_clr, wr_data, start_str, start_pat, valid, match, match_index,
      input  busy, chardata, isstring, ispattern, res_valid, res_match, res_index, res_timeout
   );
   modport slave (
      input  wr_en, wr_sel, wr_clr, wr_data, start_str, start_pat, valid, match, match_index,
      output busy, chardata, isstring, ispattern, res_valid, res_match, res_index, res_timeout
   );
endinterface

// File: rtl/sme_host_tx.sv
// sme_host_tx: buffers a string and a pattern, serializes them to the SME
// and returns its match result (or a timeout) to the controller
module sme_host_tx #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   sme_host_tx_if.slave bus
);
   localparam int SLW = $clog2(STR_MAX + 1);
   localparam int PLW = $clog2(PAT_MAX + 1);
   localparam int SIW = STR_MAX > 1 ? $clog2(STR_MAX) : 1;
   localparam int PIW = PAT_MAX > 1 ? $clog2(PAT_MAX) : 1;
   localparam int IW  = SLW > PLW ? SLW : PLW;
   localparam int TW  = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
   typedef enum logic [2:0] {IDLE, TX_STR, TX_PAT, WAIT, DONE} state_t;
   state_t         state, nstate;
   logic [7:0]     str_mem [2**SIW];
   logic [7:0]     pat_mem [2**PIW];
   logic [SLW-1:0] str_len;
   logic [PLW-1:0] pat_len;
   logic [IW-1:0]  idx, nidx;
   logic [TW-1:0]  cnt;
   logic           go_str, go_pat, wr_ok, str_wr, pat_wr, last_s, last_p, finish;
   always_comb begin
      go_str = state == IDLE && bus.start_str && str_len != '0 && pat_len != '0;
      go_pat = state == IDLE && !go_str && bus.start_pat && pat_len != '0;
      wr_ok  = state == IDLE && !go_str && !go_pat;
      str_wr = wr_ok && bus.wr_en && !bus.wr_clr && !bus.wr_sel && str_len != SLW'(STR_MAX);
      pat_wr = wr_ok && bus.wr_en && !bus.wr_clr && bus.wr_sel && pat_len != PLW'(PAT_MAX);
      last_s = idx == IW'(str_len) - IW'(1);
      last_p = idx == IW'(pat_len) - IW'(1);
      finish = bus.valid || cnt == TW'(TIMEOUT - 1);
   end
   always_comb begin
      nstate = state;
      nidx   = '0;
      case (state)
         IDLE:   nstate = go_str ? TX_STR : go_pat ? TX_PAT : IDLE;
         TX_STR: begin
            nstate = last_s ? TX_PAT : TX_STR;
            nidx   = last_s ? '0 : idx + 1'b1;
         end
         TX_PAT: begin
            nstate = last_p ? WAIT : TX_PAT;
            nidx   = last_p ? '0 : idx + 1'b1;
         end
         WAIT:   nstate = finish ? DONE : WAIT;
         default: nstate = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (str_wr) str_mem[str_len[SIW-1:0]] <= bus.wr_data;
      if (pat_wr) pat_mem[pat_len[PIW-1:0]] <= bus.wr_data;
   end
   // The bus is loaded from the next state so the first char shows one cycle after start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         idx             <= '0;
         cnt             <= '0;
         str_len         <= '0;
         pat_len         <= '0;
         bus.chardata    <= '0;
         bus.isstring    <= 1'b0;
         bus.ispattern   <= 1'b0;
         bus.res_match   <= 1'b0;
         bus.res_index   <= '0;
         bus.res_timeout <= 1'b0;
      end else begin
         state         <= nstate;
         idx           <= nidx;
         cnt           <= state == WAIT ? cnt + 1'b1 : '0;
         str_len       <= wr_ok && !bus.wr_sel && bus.wr_clr ? '0 : str_len + SLW'(str_wr);
         pat_len       <= wr_ok && bus.wr_sel && bus.wr_clr ? '0 : pat_len + PLW'(pat_wr);
         bus.chardata  <= nstate == TX_STR ? str_mem[nidx[SIW-1:0]] :
                          nstate == TX_PAT ? pat_mem[nidx[PIW-1:0]] : '0;
         bus.isstring  <= nstate == TX_STR;
         bus.ispattern <= nstate == TX_PAT;
         if (go_str || go_pat) begin
            bus.res_match   <= 1'b0;
            bus.res_index   <= '0;
            bus.res_timeout <= 1'b0;
         end else if (state == WAIT && finish) begin
            bus.res_match   <= bus.valid && bus.match;
            bus.res_index   <= bus.valid && bus.match ? bus.match_index : '0;
            bus.res_timeout <= !bus.valid;
         end
      end
   end
   always_comb begin
      bus.busy      = state != IDLE;
      bus.res_valid = state == DONE;
   end
endmodule
